// File: rtl/cell_bist_pkg.sv
// Shared types and helpers for the standard-cell BIST controller.
package cell_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_FIN
  } state_e;

  function automatic int npat(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/cell_bist_cmp.sv
// Registered comparator/accumulator: counts CUT mismatches and remembers the
// first failing pattern index of the current run.
module cell_bist_cmp #(
  parameter int N_IN = 4
) (
  input  logic            CK,
  input  logic            RST,
  input  logic            clr,
  input  logic            en,
  input  logic [N_IN-1:0] idx,
  input  logic            expected,
  input  logic            ZN,
  output logic [N_IN:0]   ERR_CNT,
  output logic [N_IN-1:0] FAIL_IDX
);

  logic [N_IN:0]   err_cnt_q, err_cnt_d;
  logic [N_IN-1:0] fail_idx_q, fail_idx_d;

  always_comb begin
    err_cnt_d  = err_cnt_q;
    fail_idx_d = fail_idx_q;
    if (clr) begin
      err_cnt_d  = '0;
      fail_idx_d = '0;
    end else if (en && (ZN != expected)) begin
      // Only the first mismatch of a run records its index.
      if (err_cnt_q == '0) fail_idx_d = idx;
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      err_cnt_q  <= '0;
      fail_idx_q <= '0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  assign ERR_CNT  = err_cnt_q;
  assign FAIL_IDX = fail_idx_q;

endmodule

// File: rtl/cell_bist.sv
// BIST controller: walks every input pattern through one combinational cell,
// compares ZN against a latched truth table and reports pass/fail.
//   state     | meaning
//   ST_IDLE   | waiting for START, last result held
//   ST_SETTLE | pattern applied, wait counter running
//   ST_SAMPLE | compare ZN for current pattern
//   ST_FIN    | DONE pulse, result final
module cell_bist
  import cell_bist_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                  CK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [2**N_IN-1:0]    TRUTH,
  output logic [N_IN-1:0]       A,
  input  logic                  ZN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  PASS,
  output logic [N_IN-1:0]       FAIL_IDX,
  output logic [N_IN:0]         ERR_CNT
);

  localparam int              NPAT     = npat(N_IN);
  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(NPAT - 1);
  localparam logic [3:0]      CNT_LAST = 4'(SETTLE - 1);

  state_e            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [NPAT-1:0]   truth_q, truth_d;
  logic              pass_q, pass_d;
  logic              clr, en, expected;

  assign expected = truth_q[idx_q];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    truth_d = truth_q;
    pass_d  = pass_q;
    clr     = 1'b0;
    en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          truth_d = TRUTH;
          idx_d   = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
          clr     = 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        en = 1'b1;
        if (idx_q == IDX_LAST) begin
          // Fold the last comparison in so PASS is already valid during DONE.
          pass_d  = (ERR_CNT == '0) && (ZN == expected);
          state_d = ST_FIN;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      truth_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      truth_q <= truth_d;
      pass_q  <= pass_d;
    end
  end

  cell_bist_cmp #(.N_IN(N_IN)) u_cmp (
    .CK       (CK),
    .RST      (RST),
    .clr      (clr),
    .en       (en),
    .idx      (idx_q),
    .expected (expected),
    .ZN       (ZN),
    .ERR_CNT  (ERR_CNT),
    .FAIL_IDX (FAIL_IDX)
  );

  assign BUSY = (state_q != ST_IDLE);
  assign DONE = (state_q == ST_FIN);
  assign A    = BUSY ? idx_q : '0;
  assign PASS = pass_q;

endmodule

// File: tb/tb_cell_bist.sv
// Bench for cell_bist: four controllers, each driving a behavioural stand-in
// for one library cell (AND4, NAND2, XNOR2, NOR3).
module tb_cell_bist;

  typedef struct packed {
    logic [3:0] a;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fidx;
    logic [4:0] err;
  } obs_t;

  logic        CK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  start_v = '0;
  logic [15:0] truth_v [4];
  logic        xnor_fault = 1'b0;

  logic [3:0] a0;  logic zn0, busy0, done0, pass0; logic [3:0] fidx0; logic [4:0] err0;
  logic [1:0] a1;  logic zn1, busy1, done1, pass1; logic [1:0] fidx1; logic [2:0] err1;
  logic [1:0] a2;  logic zn2, busy2, done2, pass2; logic [1:0] fidx2; logic [2:0] err2;
  logic [2:0] a3;  logic zn3, busy3, done3, pass3; logic [2:0] fidx3; logic [3:0] err3;

  int errors = 0;
  int checks = 0;

  always #5 CK = ~CK;

  // Behavioural cell models standing in for the library CUTs.
  assign zn0 = &a0;
  assign zn1 = ~&a1;
  assign zn2 = (xnor_fault && a2 == 2'd3) ? 1'b0 : ~(a2[0] ^ a2[1]);
  assign zn3 = ~|a3;

  cell_bist #(.N_IN(4), .SETTLE(1)) u_and4 (
    .CK(CK), .RST(RST), .START(start_v[0]), .TRUTH(truth_v[0]), .A(a0), .ZN(zn0),
    .BUSY(busy0), .DONE(done0), .PASS(pass0), .FAIL_IDX(fidx0), .ERR_CNT(err0));
  cell_bist #(.N_IN(2), .SETTLE(3)) u_nand2 (
    .CK(CK), .RST(RST), .START(start_v[1]), .TRUTH(truth_v[1][3:0]), .A(a1), .ZN(zn1),
    .BUSY(busy1), .DONE(done1), .PASS(pass1), .FAIL_IDX(fidx1), .ERR_CNT(err1));
  cell_bist #(.N_IN(2), .SETTLE(2)) u_xnor2 (
    .CK(CK), .RST(RST), .START(start_v[2]), .TRUTH(truth_v[2][3:0]), .A(a2), .ZN(zn2),
    .BUSY(busy2), .DONE(done2), .PASS(pass2), .FAIL_IDX(fidx2), .ERR_CNT(err2));
  cell_bist #(.N_IN(3), .SETTLE(1)) u_nor3 (
    .CK(CK), .RST(RST), .START(start_v[3]), .TRUTH(truth_v[3][7:0]), .A(a3), .ZN(zn3),
    .BUSY(busy3), .DONE(done3), .PASS(pass3), .FAIL_IDX(fidx3), .ERR_CNT(err3));

  function automatic int nin_of(input int d);
    case (d) 0: return 4; 1: return 2; 2: return 2; default: return 3; endcase
  endfunction

  function automatic int settle_of(input int d);
    case (d) 0: return 1; 1: return 3; 2: return 2; default: return 1; endcase
  endfunction

  // Logic function of each cell for input pattern k.
  function automatic bit cell_out(input int d, input int k);
    case (d)
      0: return k == 15;
      1: return k != 3;
      2: return (xnor_fault && k == 3) ? 1'b0 : ((k & 1) == ((k >> 1) & 1));
      default: return k == 0;
    endcase
  endfunction

  function automatic obs_t observe(input int d);
    obs_t o;
    o = '0;
    case (d)
      0: begin o.a = a0; o.busy = busy0; o.done = done0; o.pass = pass0; o.fidx = fidx0; o.err = err0; end
      1: begin o.a = 4'(a1); o.busy = busy1; o.done = done1; o.pass = pass1; o.fidx = 4'(fidx1); o.err = 5'(err1); end
      2: begin o.a = 4'(a2); o.busy = busy2; o.done = done2; o.pass = pass2; o.fidx = 4'(fidx2); o.err = 5'(err2); end
      default: begin o.a = 4'(a3); o.busy = busy3; o.done = done3; o.pass = pass3; o.fidx = 4'(fidx3); o.err = 5'(err3); end
    endcase
    return o;
  endfunction

  // Full run on controller d; must be entered at a negedge. Optionally re-pulses
  // START mid-run and in the FIN cycle and scrambles TRUTH mid-run.
  task automatic do_run(input int d, input logic [15:0] tv, input bit disturb, input string name);
    int np, s, cfin, exp_err, exp_fail;
    bit exp_pass;
    obs_t o;
    np = 1 << nin_of(d);
    s  = settle_of(d);
    cfin = np * (s + 1) + 1;
    exp_err = 0;
    exp_fail = 0;
    for (int k = 0; k < np; k++) begin
      if (cell_out(d, k) != tv[k]) begin
        if (exp_err == 0) exp_fail = k;
        exp_err++;
      end
    end
    exp_pass = (exp_err == 0);
    truth_v[d] = tv;
    start_v[d] = 1'b1;
    for (int c = 1; c <= cfin + 1; c++) begin
      @(negedge CK);
      o = observe(d);
      checks++;
      if (c < cfin) begin
        if (o.busy !== 1'b1 || o.done !== 1'b0 || o.a !== 4'((c - 1) / (s + 1))) begin
          errors++;
          $display("FAIL %s run cyc %0d: busy=%0b done=%0b A=%0d, want busy=1 done=0 A=%0d",
                   name, c, o.busy, o.done, o.a, (c - 1) / (s + 1));
        end
      end else if (c == cfin) begin
        if (o.busy !== 1'b1 || o.done !== 1'b1 || o.pass !== exp_pass ||
            o.err !== 5'(exp_err) || o.fidx !== 4'(exp_fail)) begin
          errors++;
          $display("FAIL %s fin: busy=%0b done=%0b pass=%0b err=%0d fidx=%0d, want 1 1 %0b %0d %0d",
                   name, o.busy, o.done, o.pass, o.err, o.fidx, exp_pass, exp_err, exp_fail);
        end
      end else begin
        if (o.busy !== 1'b0 || o.done !== 1'b0 || o.a !== 4'd0 || o.pass !== exp_pass ||
            o.err !== 5'(exp_err) || o.fidx !== 4'(exp_fail)) begin
          errors++;
          $display("FAIL %s idle: busy=%0b done=%0b A=%0d pass=%0b err=%0d fidx=%0d, want 0 0 0 %0b %0d %0d",
                   name, o.busy, o.done, o.a, o.pass, o.err, o.fidx, exp_pass, exp_err, exp_fail);
        end
      end
      start_v[d] = disturb && (c == 5 || c == cfin);
      if (disturb && c == 7) truth_v[d] = ~tv;
    end
  endtask

  task automatic test_reset();
    obs_t o;
    RST = 1'b1;
    for (int d = 0; d < 4; d++) truth_v[d] = 16'hFFFF;
    repeat (3) @(negedge CK);
    for (int d = 0; d < 4; d++) begin
      o = observe(d);
      checks++;
      if (o !== obs_t'(0)) begin
        errors++;
        $display("FAIL reset dut%0d: obs=%h, want 0", d, o);
      end
    end
    RST = 1'b0;
  endtask

  task automatic test_and4();
    do_run(0, 16'h8000, 1'b0, "and4");
  endtask

  task automatic test_nand2();
    do_run(1, 16'h0007, 1'b0, "nand2_ok");
    do_run(1, 16'h0006, 1'b0, "nand2_bad");
  endtask

  task automatic test_xnor2_fault();
    xnor_fault = 1'b1;
    do_run(2, 16'h0009, 1'b0, "xnor2_fault");
    xnor_fault = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_run(3, 16'h0001, 1'b1, "nor3_disturb");
    do_run(3, 16'h0001, 1'b0, "nor3_second");
  endtask

  task automatic test_rst_midrun();
    obs_t o;
    int done_seen;
    truth_v[0] = 16'h7FFF;
    start_v[0] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CK);
      start_v[0] = 1'b0;
    end
    RST = 1'b1;
    @(negedge CK);
    o = observe(0);
    checks++;
    if (o !== obs_t'(0)) begin
      errors++;
      $display("FAIL rst_midrun: obs=%h, want 0", o);
    end
    RST = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CK);
      if (done0 !== 1'b0 || busy0 !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL rst_no_done: active cycles=%0d, want 0", done_seen);
    end
    do_run(0, 16'h8000, 1'b0, "and4_after_rst");
  endtask

  task automatic test_rst_start();
    obs_t o;
    RST = 1'b1;
    start_v[0] = 1'b1;
    truth_v[0] = 16'h8000;
    @(negedge CK);
    RST = 1'b0;
    start_v[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CK);
      o = observe(0);
      checks++;
      if (o.busy !== 1'b0 || o.a !== 4'd0) begin
        errors++;
        $display("FAIL rst_start cyc %0d: busy=%0b A=%0d, want 0 0", c, o.busy, o.a);
      end
    end
  endtask

  task automatic test_random();
    int d, np;
    logic [15:0] tv;
    for (int it = 0; it < 8; it++) begin
      d = $urandom_range(0, 3);
      np = 1 << nin_of(d);
      xnor_fault = (d == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      tv = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < np; k++) tv[k] = cell_out(d, k);
      end
      do_run(d, tv, 1'($urandom_range(0, 1)), $sformatf("rand%0d_dut%0d", it, d));
    end
    xnor_fault = 1'b0;
  endtask

  initial begin
    test_reset();
    test_and4();
    test_nand2();
    test_xnor2_fault();
    test_back_to_back();
    test_rst_midrun();
    test_rst_start();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
